// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel array frame sequencer:
//   - pixel_state_t : frame sequencer states, IDLE through DONE
//   - DEF_*         : default array geometry and timing constants
//   - width_of()    : index width for a count of items, never below 1 bit
//   - max3()        : largest of three widths, used to size the shared timer
// -----------------------------------------------------------------------------
package pixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_ROW_SEL,
        ST_ROW_READ,
        ST_DONE
    } pixel_state_t;

    localparam int DEF_N_ROWS       = 2;
    localparam int DEF_N_COLS       = 2;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_EXP_W        = 16;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// -----------------------------------------------------------------------------
// pixel_phase_timer
// Loadable down-counter with a terminal-count flag. The sequencer loads it
// with (phase length - 1) on the edge that enters a phase; tc is then high
// in the last cycle of that phase. The count parks at 0 when not loaded.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : load value into the counter (priority over counting)
//   value      : value to load
//   count      : current count
//   tc         : count is zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module pixel_phase_timer
    import pixel_pkg::*;
#(
    parameter int W = DEF_EXP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         tc
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/pixel_array_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_array_ctrl
// Frame sequencer for the pixel array. A start request in IDLE runs one frame:
// erase, expose, ramp conversion, then row-by-row readout, ending with a
// one-cycle done pulse. Every output is a register loaded from the next-state
// decode, so the strobes change on the same edge as the state.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (aborts a frame)
//   start       : frame request, honoured only in IDLE
//   expose_len  : exposure length in cycles, latched at start (0 acts as 1)
//   busy        : high in every state except IDLE
//   done        : one-cycle frame completion pulse
//   erase       : array ERASE strobe
//   expose      : array EXPOSE strobe
//   convert     : ramp enable while adc_count sweeps
//   adc_count   : shared ramp/ADC code
//   read        : array READ strobe
//   row_pointer : selected row
//   col_index   : column of the pixel currently on the array's out_data
//   pix_valid   : out_data holds a valid pixel (one cycle after each read)
// -----------------------------------------------------------------------------
module pixel_array_ctrl
    import pixel_pkg::*;
#(
    parameter int N_ROWS       = DEF_N_ROWS,
    parameter int N_COLS       = DEF_N_COLS,
    parameter int ROW_W        = width_of(N_ROWS),
    parameter int COL_W        = width_of(N_COLS),
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int EXP_W        = DEF_EXP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] expose_len,
    output logic             busy,
    output logic             done,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic [CNT_W-1:0] adc_count,
    output logic             read,
    output logic [ROW_W-1:0] row_pointer,
    output logic [COL_W-1:0] col_index,
    output logic             pix_valid
);

    // One timer serves erase, expose and column phases, so it must hold the
    // largest reload value of the three.
    localparam int TIMER_W = max3(EXP_W, width_of(ERASE_CYCLES), width_of(N_COLS));

    pixel_state_t       state;
    pixel_state_t       state_d;
    logic [EXP_W-1:0]   exp_len;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_value;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_tc;
    logic [COL_W-1:0]   col_cur;

    logic [CNT_W-1:0]   adc_d;
    logic [ROW_W-1:0]   row_d;
    logic [COL_W-1:0]   col_d;

    pixel_phase_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .count (tmr_count),
        .tc    (tmr_tc)
    );

    // The timer counts down through a row, so the column being read is the
    // distance from the reload value.
    assign col_cur = COL_W'(TIMER_W'(N_COLS - 1) - tmr_count);

    // Next-state and timer reload.
    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ERASE;
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(ERASE_CYCLES - 1);
                end
            end
            ST_ERASE: begin
                if (tmr_tc) begin
                    state_d   = ST_EXPOSE;
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(exp_len - EXP_W'(1));
                end
            end
            ST_EXPOSE: begin
                if (tmr_tc) begin
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // The ramp code itself marks the end of conversion.
                if (adc_count == '1) begin
                    state_d = ST_ROW_SEL;
                end
            end
            ST_ROW_SEL: begin
                state_d   = ST_ROW_READ;
                tmr_load  = 1'b1;
                tmr_value = TIMER_W'(N_COLS - 1);
            end
            ST_ROW_READ: begin
                if (tmr_tc) begin
                    state_d = (row_pointer == ROW_W'(N_ROWS - 1)) ? ST_DONE : ST_ROW_SEL;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the counter-style outputs.
    always_comb begin
        adc_d = adc_count;
        if (state_d == ST_IDLE) begin
            adc_d = '0;
        end else if (state_d == ST_CONVERT) begin
            adc_d = (state == ST_CONVERT) ? adc_count + CNT_W'(1) : '0;
        end

        row_d = row_pointer;
        if (state_d == ST_IDLE) begin
            row_d = '0;
        end else if (state_d == ST_ROW_SEL) begin
            row_d = (state == ST_ROW_READ) ? row_pointer + ROW_W'(1) : '0;
        end

        // The array registers the pixel selected in a read cycle, so the
        // column tag lags the read by one cycle.
        col_d = (state == ST_ROW_READ) ? col_cur : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            exp_len     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            adc_count   <= '0;
            read        <= 1'b0;
            row_pointer <= '0;
            col_index   <= '0;
            pix_valid   <= 1'b0;
        end else begin
            state       <= state_d;
            busy        <= (state_d != ST_IDLE);
            done        <= (state_d == ST_DONE);
            erase       <= (state_d == ST_ERASE);
            expose      <= (state_d == ST_EXPOSE);
            convert     <= (state_d == ST_CONVERT);
            adc_count   <= adc_d;
            read        <= (state_d == ST_ROW_READ);
            row_pointer <= row_d;
            col_index   <= col_d;
            pix_valid   <= (state == ST_ROW_READ);
            if (state == ST_IDLE && start) begin
                exp_len <= (expose_len == '0) ? EXP_W'(1) : expose_len;
            end
        end
    end

endmodule
